// File: rtl/icache_nway.sv
//------------------------------------------------------------------------------
// Module   : icache_nway
// Purpose  : Parametrised N-way set-associative blocking instruction cache
//            sitting between the fetch stage and the AXI read bridge.
//            Supports back-to-back hits, uncached fetches, a whole-cache
//            invalidate walk and a memory request handshake.
// Ports    : clk, reset_n                 clock / async active-low reset
//            req_valid/addr/uncached/ready fetch request handshake
//            resp_valid, resp_inst         one-cycle response pulse + data
//            inv_req, inv_done             invalidate-all request / done pulse
//            rd_req/type/addr, rd_rdy      memory read request handshake
//            ret_valid, ret_data           single-beat memory return
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module icache_nway #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 128,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic                    req_uncached,
  output logic                    req_ready,
  output logic                    resp_valid,
  output logic [31:0]             resp_inst,
  input  logic                    inv_req,
  output logic                    inv_done,
  output logic                    rd_req,
  output logic                    rd_type,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_rdy,
  input  logic                    ret_valid,
  input  logic [LINE_BYTES*8-1:0] ret_data
);

  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WSEL_W = OFF_W - 2;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MISS   = 3'd2,
    S_REFILL = 3'd3,
    S_INV    = 3'd4
  } state_t;

  state_t state, state_nx;

  // Captured request, held as a word address (byte offset bits dropped).
  logic [ADDR_W-3:0] req_q;
  logic              unc_q;
  logic              armed;     // low for the first cycle out of reset
  logic [IDX_W-1:0]  inv_cnt;

  logic [WAYS-1:0]   valid [SETS];
  logic [WAY_W-1:0]  ptr   [SETS];

  logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0] data_mem [WAYS][SETS];
  logic [TAG_W-1:0]  tag_rd   [WAYS];
  logic [LINE_W-1:0] data_rd  [WAYS];

  logic              accept;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  q_idx;
  logic [TAG_W-1:0]  q_tag;
  logic [WSEL_W-1:0] q_wsel;
  logic              hit;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       hit_word;
  logic [31:0]       ret_word;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  ptr_nx;
  logic              fill_we;

  assign accept  = req_valid & req_ready;
  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign q_idx   = req_q[OFF_W-2 +: IDX_W];
  assign q_tag   = req_q[ADDR_W-3 -: TAG_W];
  assign q_wsel  = req_q[0 +: WSEL_W];

  assign hit_word = hit_line[{q_wsel, 5'b0} +: 32];
  assign ret_word = ret_data[{q_wsel, 5'b0} +: 32];
  assign fill_we  = (state == S_REFILL) && ret_valid && !unc_q;
  assign ptr_nx   = (ptr[q_idx] == WAY_W'(WAYS-1)) ? '0 : ptr[q_idx] + WAY_W'(1);

  // Tag/data arrays: synchronous read at accept, write on cached refill.
  // A refill never coincides with an accept (req_ready is low in REFILL),
  // so the read issued by the next accept always observes the new line.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (fill_we && (victim == WAY_W'(w))) begin
        tag_mem[w][q_idx]  <= q_tag;
        data_mem[w][q_idx] <= ret_data;
      end
      if (accept) begin
        tag_rd[w]  <= tag_mem[w][req_idx];
        data_rd[w] <= data_mem[w][req_idx];
      end
    end
  end

  // Hit detection against the registered array outputs.
  always_comb begin
    hit      = 1'b0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[q_idx][w] && (tag_rd[w] == q_tag)) begin
        hit      = 1'b1;
        hit_line = data_rd[w];
      end
    end
  end

  // Victim: lowest-index invalid way, otherwise the round-robin pointer.
  always_comb begin
    victim = ptr[q_idx];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid[q_idx][w]) victim = WAY_W'(w);
    end
  end

  // Next state and outputs.
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_inst  = '0;
    inv_done   = 1'b0;
    rd_req     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = armed && !inv_req;
        if (inv_req)                 state_nx = S_INV;
        else if (armed && req_valid) state_nx = req_uncached ? S_MISS : S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_inst  = hit_word;
          req_ready  = !inv_req;
          if (!inv_req && req_valid) state_nx = req_uncached ? S_MISS : S_LOOKUP;
          else                       state_nx = S_IDLE;
        end else begin
          state_nx = S_MISS;
        end
      end
      S_MISS: begin
        rd_req = 1'b1;
        if (rd_rdy) state_nx = S_REFILL;
      end
      S_REFILL: begin
        if (ret_valid) begin
          resp_valid = 1'b1;
          resp_inst  = unc_q ? ret_data[31:0] : ret_word;
          state_nx   = S_IDLE;
        end
      end
      S_INV: begin
        if (inv_cnt == IDX_W'(SETS-1)) begin
          inv_done = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      req_q   <= '0;
      unc_q   <= 1'b0;
      rd_addr <= '0;
      rd_type <= 1'b0;
      inv_cnt <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        ptr[s]   <= '0;
      end
    end else begin
      state <= state_nx;
      armed <= 1'b1;

      if (accept) begin
        req_q <= req_addr[ADDR_W-1:2];
        unc_q <= req_uncached;
      end

      // Memory request address is latched on entry to MISS and held there.
      if (accept && req_uncached) begin
        rd_addr <= req_addr;
        rd_type <= 1'b0;
      end else if ((state == S_LOOKUP) && !hit) begin
        rd_addr <= {req_q[ADDR_W-3:OFF_W-2], {OFF_W{1'b0}}};
        rd_type <= 1'b1;
      end

      if (state == S_INV) begin
        valid[inv_cnt] <= '0;
        inv_cnt        <= inv_cnt + IDX_W'(1);
      end else begin
        inv_cnt <= '0;
      end

      if (fill_we) begin
        valid[q_idx][victim] <= 1'b1;
        if (&valid[q_idx]) ptr[q_idx] <= ptr_nx;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icache_nway.sv
//------------------------------------------------------------------------------
// Module   : tb_icache_nway
// Purpose  : Self-checking bench for icache_nway (default parameters).
//            Backing memory is a pure function of address; a set/way model
//            predicts hit or miss for every fetch.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_icache_nway;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid, req_uncached, req_ready;
  logic [31:0]  req_addr;
  logic         resp_valid;
  logic [31:0]  resp_inst;
  logic         inv_req, inv_done;
  logic         rd_req, rd_type, rd_rdy;
  logic [31:0]  rd_addr;
  logic         ret_valid;
  logic [255:0] ret_data;

  int checks = 0;
  int errors = 0;

  icache_nway dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_uncached(req_uncached),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_inst   (resp_inst),
    .inv_req     (inv_req),
    .inv_done    (inv_done),
    .rd_req      (rd_req),
    .rd_type     (rd_type),
    .rd_addr     (rd_addr),
    .rd_rdy      (rd_rdy),
    .ret_valid   (ret_valid),
    .ret_data    (ret_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  logic [19:0] m_tag [128][2];
  bit          m_val [128][2];
  int          m_ptr [128];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1C000004) return 32'h02800C0C;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  base;
    base = {a[31:5], 5'b0};
    for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(base + 32'(4*i));
    return l;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    int s = int'(a[11:5]);
    for (int w = 0; w < 2; w++)
      if (m_val[s][w] && m_tag[s][w] == a[31:12]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_fill(input logic [31:0] a);
    int s = int'(a[11:5]);
    int w;
    if (!m_val[s][0])      w = 0;
    else if (!m_val[s][1]) w = 1;
    else begin
      w = m_ptr[s];
      m_ptr[s] = (m_ptr[s] + 1) % 2;
    end
    m_val[s][w] = 1'b1;
    m_tag[s][w] = a[31:12];
  endfunction

  function automatic void m_clear(input bit ptrs_too);
    for (int s = 0; s < 128; s++) begin
      m_val[s][0] = 1'b0;
      m_val[s][1] = 1'b0;
      if (ptrs_too) m_ptr[s] = 0;
    end
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One complete fetch; services the memory side if the DUT asks for it.
  task automatic fetch(input logic [31:0] a, input logic unc, input bit raise_inv,
                       output bit was_hit);
    logic [31:0] got, exp_ra;
    bit          done, exp_hit;
    int          n;
    exp_hit = !unc && m_hit(a);
    exp_ra  = unc ? a : {a[31:5], 5'b0};
    was_hit = 1'b0;
    done    = 1'b0;
    got     = '0;
    req_valid = 1'b1; req_addr = a; req_uncached = unc;
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("accept", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_uncached = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (resp_valid) begin
        was_hit = 1'b1; got = resp_inst; done = 1'b1;
      end else if (rd_req) begin
        chk("rd_type", 64'(rd_type), 64'(!unc));
        chk("rd_addr", 64'(rd_addr), 64'(exp_ra));
        if (raise_inv) inv_req = 1'b1;
        repeat ($urandom_range(0, 2)) begin
          ret_valid = 1'b1;
          for (int i = 0; i < 8; i++) ret_data[32*i +: 32] = $urandom;
          #1;
          chk("ret_in_miss_dropped", 64'(resp_valid), 64'd0);
          @(negedge clk);
          ret_valid = 1'b0;
          chk("rd_held", {31'd0, rd_req, rd_addr}, {31'd0, 1'b1, exp_ra});
        end
        rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ret_valid = 1'b1;
        if (unc) begin
          for (int i = 1; i < 8; i++) ret_data[32*i +: 32] = $urandom;
          ret_data[31:0] = mem_word(a);
        end else begin
          ret_data = mem_line(a);
        end
        #1;
        chk("refill_resp_valid", 64'(resp_valid), 64'd1);
        got = resp_inst; done = 1'b1;
        @(negedge clk);
        ret_valid = 1'b0;
      end else begin
        chk("miss_ready_low", 64'(req_ready), 64'd0);
        @(negedge clk);
      end
    end
    if (!done) chk("resp_timeout", 64'd0, 64'd1);
    chk("hit_vs_model", 64'(was_hit), 64'(exp_hit));
    chk("resp_inst", 64'(got), 64'(mem_word(a)));
    if (!exp_hit && !unc) m_fill(a);
  endtask

  task automatic inv_walk();
    int k;
    bit seen, ready_seen;
    if (!inv_req) begin
      @(negedge clk);
      inv_req = 1'b1;
    end
    #1;
    chk("inv_ready_low_start", 64'(req_ready), 64'd0);
    seen = 1'b0; ready_seen = 1'b0; k = 0;
    while (!seen && k < 300) begin
      @(negedge clk);
      k++;
      if (req_ready) ready_seen = 1'b1;
      if (inv_done) begin seen = 1'b1; inv_req = 1'b0; end
    end
    chk("inv_cycles", 64'(k), 64'd128);
    chk("inv_ready_low", 64'(ready_seen), 64'd0);
    @(negedge clk);
    chk("inv_done_pulse", 64'(inv_done), 64'd0);
    m_clear(1'b0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] addr;
    logic        unc;
    logic        exp_hit;
  } vec_t;

  vec_t tbl [11];

  initial begin
    bit h;
    int n;
    logic [31:0] a;

    tbl[0]  = '{32'h1C000004, 1'b0, 1'b0};  // cold miss
    tbl[1]  = '{32'h100000A0, 1'b0, 1'b0};  // A -> way0
    tbl[2]  = '{32'h200000A0, 1'b0, 1'b0};  // B -> way1
    tbl[3]  = '{32'h300000A0, 1'b0, 1'b0};  // C replaces A
    tbl[4]  = '{32'h400000A4, 1'b0, 1'b0};  // D replaces B
    tbl[5]  = '{32'h300000B8, 1'b0, 1'b1};  // C hits
    tbl[6]  = '{32'h100000A0, 1'b0, 1'b0};  // A misses, replaces C
    tbl[7]  = '{32'h400000BC, 1'b0, 1'b1};  // D hits
    tbl[8]  = '{32'hBFC00000, 1'b1, 1'b0};  // uncached
    tbl[9]  = '{32'hBFC00000, 1'b1, 1'b0};  // uncached again, still misses
    tbl[10] = '{32'h1C000010, 1'b0, 1'b1};  // line from first refill still there

    reset_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_uncached = 1'b0;
    inv_req = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_data = '0;
    m_clear(1'b1);
    repeat (3) @(negedge clk);
    chk("reset_ctl", {59'd0, req_ready, resp_valid, inv_done, rd_req, rd_type}, 64'd0);
    chk("reset_inst", 64'(resp_inst), 64'd0);
    chk("reset_rd_addr", 64'(rd_addr), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      fetch(tbl[i].addr, tbl[i].unc, 1'b0, h);
      chk("table_hit", 64'(h), 64'(tbl[i].exp_hit));
    end

    // Eight back-to-back hits across the line filled by the cold miss.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      a = 32'h1C000000 + 32'(4*i);
      req_valid = 1'b1; req_addr = a; req_uncached = 1'b0;
      @(negedge clk);
      chk("b2b_resp", {31'd0, resp_valid, resp_inst}, {31'd0, 1'b1, mem_word(a)});
      chk("b2b_no_rd_req", 64'(rd_req), 64'd0);
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Invalidate walk, then a previously hitting address must miss.
    inv_walk();
    fetch(32'h1C000000, 1'b0, 1'b0, h);
    chk("post_inv_miss", 64'(h), 64'd0);

    // inv_req raised during a miss: refill completes, then the line is wiped.
    fetch(32'h55500020, 1'b0, 1'b1, h);
    inv_walk();
    fetch(32'h55500024, 1'b0, 1'b0, h);
    chk("inv_after_refill_miss", 64'(h), 64'd0);

    // Reset in the middle of a refill, then a stray return beat.
    a = 32'h70000040;
    req_valid = 1'b1; req_addr = a; req_uncached = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rd_req && n < 50) begin @(negedge clk); n++; end
    chk("rst_seq_rd_req", 64'(rd_req), 64'd1);
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {59'd0, req_ready, resp_valid, inv_done, rd_req, rd_type}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_clear(1'b1);
    ret_valid = 1'b1; ret_data = mem_line(a);
    #1;
    chk("stray_ret_ignored", 64'(resp_valid), 64'd0);
    @(negedge clk);
    ret_valid = 1'b0;
    @(negedge clk);
    fetch(a, 1'b0, 1'b0, h);
    chk("rst_refill_discarded", 64'(h), 64'd0);

    // Randomised traffic over a small tag/set pool to force conflicts.
    for (int it = 0; it < 150; it++) begin
      logic [7:0] tg;
      logic [6:0] st;
      logic [2:0] wd;
      bit         unc, rinv;
      tg = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       st = 7'd5;
        1:       st = 7'd9;
        default: st = 7'd127;
      endcase
      wd   = 3'($urandom_range(0, 7));
      unc  = ($urandom_range(0, 9) == 0);
      rinv = ($urandom_range(0, 29) == 0);
      a = {12'hABC, tg, st, wd, 2'b00};
      fetch(a, unc, rinv, h);
      if (inv_req || $urandom_range(0, 49) == 0) inv_walk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
